// File: rtl/flash_cache_pkg.sv
// Shared types and constants for the flash fetch cache.
package flash_cache_pkg;

    localparam int ADDR_W      = 24;
    localparam int DATA_W      = 32;
    localparam int WORD_ADDR_W = 22;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT
    } state_t;

    function automatic logic [ADDR_W-1:0] word_align(input logic [ADDR_W-1:0] addr);
        return {addr[ADDR_W-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/flash_cache_tag_ram.sv
// Register-based valid/tag/data store: combinational read, one write port, global invalidate.
module flash_cache_tag_ram
    import flash_cache_pkg::*;
#(
    parameter int INDEX_BITS = 4,
    parameter int TAG_W      = WORD_ADDR_W - INDEX_BITS
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  inv,
    input  logic [INDEX_BITS-1:0] rd_idx,
    output logic                  rd_valid,
    output logic [TAG_W-1:0]      rd_tag,
    output logic [DATA_W-1:0]     rd_data,
    input  logic                  wr_en,
    input  logic [INDEX_BITS-1:0] wr_idx,
    input  logic [TAG_W-1:0]      wr_tag,
    input  logic [DATA_W-1:0]     wr_data
);

    localparam int LINES = 1 << INDEX_BITS;

    logic [LINES-1:0]             valid_q;
    logic [LINES-1:0][TAG_W-1:0]  tag_q;
    logic [LINES-1:0][DATA_W-1:0] data_q;

    // Invalidate wins over a same-cycle fill.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            valid_q <= '0;
        else if (inv)
            valid_q <= '0;
        else if (wr_en)
            valid_q[wr_idx] <= 1'b1;
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            tag_q[wr_idx]  <= wr_tag;
            data_q[wr_idx] <= wr_data;
        end
    end

    assign rd_valid = valid_q[rd_idx];
    assign rd_tag   = tag_q[rd_idx];
    assign rd_data  = data_q[rd_idx];

endmodule

// File: rtl/flash_fetch_cache.sv
// Direct-mapped word cache in front of the SPI flash read controller, with fetch timeout.
// Optional hit/miss counters when FLASH_CACHE_STATS_EN is defined.
module flash_fetch_cache
    import flash_cache_pkg::*;
#(
    parameter int INDEX_BITS     = 4,
    parameter int TIMEOUT_CYCLES = 1023
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cpu_req,
    input  logic [ADDR_W-1:0] cpu_addr,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_ready,
    output logic              cpu_err,
    input  logic              inv,
    output logic              fl_re,
    output logic [ADDR_W-1:0] fl_addr,
    input  logic [DATA_W-1:0] fl_rdata,
    input  logic              fl_done
`ifdef FLASH_CACHE_STATS_EN
    ,
    output logic [31:0]       hit_cnt,
    output logic [31:0]       miss_cnt
`endif
);

    localparam int TAG_W = WORD_ADDR_W - INDEX_BITS;
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] TMO_MAX = CNT_W'(TIMEOUT_CYCLES);

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   req_addr;
    logic [CNT_W-1:0]    tmo_cnt;
    logic                squash;
    logic                accept, hit, fill, tmo;

    logic                rd_valid;
    logic [TAG_W-1:0]    rd_tag;
    logic [DATA_W-1:0]   rd_data;

    logic [INDEX_BITS-1:0] cpu_idx, req_idx;
    logic [TAG_W-1:0]      cpu_tag, req_tag;

    assign cpu_idx = cpu_addr[2 +: INDEX_BITS];
    assign cpu_tag = cpu_addr[ADDR_W-1 : 2+INDEX_BITS];
    assign req_idx = req_addr[2 +: INDEX_BITS];
    assign req_tag = req_addr[ADDR_W-1 : 2+INDEX_BITS];

    flash_cache_tag_ram #(
        .INDEX_BITS (INDEX_BITS),
        .TAG_W      (TAG_W)
    ) u_tag_ram (
        .clk      (clk),
        .rst_n    (rst_n),
        .inv      (inv),
        .rd_idx   (cpu_idx),
        .rd_valid (rd_valid),
        .rd_tag   (rd_tag),
        .rd_data  (rd_data),
        .wr_en    (fill && !squash),
        .wr_idx   (req_idx),
        .wr_tag   (req_tag),
        .wr_data  (fl_rdata)
    );

    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        hit     = 1'b0;
        fill    = 1'b0;
        tmo     = 1'b0;
        case (state_q)
            IDLE: begin
                // Holding off while cpu_ready is high stops a held request re-accepting.
                if (cpu_req && !cpu_ready) begin
                    accept = 1'b1;
                    if (rd_valid && (rd_tag == cpu_tag))
                        hit = 1'b1;
                    else
                        state_d = ISSUE;
                end
            end
            ISSUE: state_d = WAIT;
            WAIT: begin
                if (fl_done) begin
                    fill    = 1'b1;
                    state_d = IDLE;
                end else if (tmo_cnt == TMO_MAX) begin
                    tmo     = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            req_addr  <= '0;
            tmo_cnt   <= '0;
            squash    <= 1'b0;
            fl_re     <= 1'b0;
            fl_addr   <= '0;
            cpu_ready <= 1'b0;
            cpu_err   <= 1'b0;
            cpu_rdata <= '0;
        end else begin
            state_q   <= state_d;
            cpu_ready <= hit || fill || tmo;
            cpu_err   <= tmo;
            fl_re     <= (state_q == ISSUE);
            if (accept)
                req_addr <= word_align(cpu_addr);
            if (state_q == ISSUE)
                fl_addr <= word_align(req_addr);
            if (hit)
                cpu_rdata <= rd_data;
            else if (fill)
                cpu_rdata <= fl_rdata;
            else if (tmo)
                cpu_rdata <= '0;
            if (state_q == ISSUE)
                tmo_cnt <= '0;
            else if (state_q == WAIT && tmo_cnt != TMO_MAX)
                tmo_cnt <= tmo_cnt + CNT_W'(1);
            // An invalidate during the miss must keep the in-flight fill from revalidating the line.
            if (state_d == IDLE)
                squash <= 1'b0;
            else if (inv && state_q != IDLE)
                squash <= 1'b1;
        end
    end

`ifdef FLASH_CACHE_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hit_cnt  <= '0;
            miss_cnt <= '0;
        end else begin
            if (hit)
                hit_cnt <= hit_cnt + 32'd1;
            if (accept && !hit)
                miss_cnt <= miss_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_flash_fetch_cache.sv
// Directed bench for flash_fetch_cache with a response scoreboard and a simple flash responder.
module tb_flash_fetch_cache;

    localparam int TMO = 1023;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        cpu_req = 1'b0;
    logic [23:0] cpu_addr = '0;
    logic        inv = 1'b0;
    logic [31:0] fl_rdata = '0;
    logic        fl_done = 1'b0;
    logic [31:0] cpu_rdata;
    logic        cpu_ready, cpu_err, fl_re;
    logic [23:0] fl_addr;
`ifdef FLASH_CACHE_STATS_EN
    logic [31:0] hit_cnt, miss_cnt;
`endif

    int passed = 0;
    int total  = 0;
    logic [32:0] exp_q[$];

    always #5 clk = ~clk;

    flash_fetch_cache #(.INDEX_BITS(4), .TIMEOUT_CYCLES(TMO)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cpu_req   (cpu_req),
        .cpu_addr  (cpu_addr),
        .cpu_rdata (cpu_rdata),
        .cpu_ready (cpu_ready),
        .cpu_err   (cpu_err),
        .inv       (inv),
        .fl_re     (fl_re),
        .fl_addr   (fl_addr),
        .fl_rdata  (fl_rdata),
        .fl_done   (fl_done)
`ifdef FLASH_CACHE_STATS_EN
        ,
        .hit_cnt   (hit_cnt),
        .miss_cnt  (miss_cnt)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // One CPU read; flash answers fdelay cycles after fl_re unless drop. inv pulses at cycle inv_at.
    task automatic read(input logic [23:0] a, input bit miss, input int fdelay,
                        input logic [31:0] fdata, input bit drop, input int inv_at,
                        input logic [31:0] exp_d, input bit exp_e, output int lat);
        int re_cnt, done_at;
        bit got;
        logic [32:0] exp;
        logic [23:0] exp_fa;
        re_cnt = 0; done_at = -1; got = 1'b0; lat = -1;
        exp_fa = {a[23:2], 2'b00};
        exp_q.push_back({exp_e, exp_d});
        cpu_req = 1'b1; cpu_addr = a; inv = (inv_at == 0);
        for (int c = 1; c <= TMO + 200 && !got; c++) begin
            @(negedge clk);
            if (fl_re) begin
                re_cnt++;
                check("fl_addr", 32'(fl_addr), 32'(exp_fa));
                done_at = c + fdelay;
            end
            if (cpu_ready) begin
                got = 1'b1;
                lat = c;
                exp = exp_q.pop_front();
                check("rdata", cpu_rdata, exp[31:0]);
                check("err", 32'(cpu_err), 32'(exp[32]));
                cpu_req = 1'b0;
            end
            inv      = (c == inv_at);
            fl_done  = !drop && (c == done_at);
            fl_rdata = fl_done ? fdata : 32'h0;
        end
        cpu_req = 1'b0; inv = 1'b0; fl_done = 1'b0;
        check("ready_seen", 32'(got), 32'd1);
        if (!got) void'(exp_q.pop_front());
        check("fl_re_cnt", 32'(re_cnt), 32'(miss));
        if (got && !miss) check("hit_lat", 32'(lat), 32'd1);
        else if (got && !drop) check("miss_lat", 32'(lat), 32'(fdelay + 3));
        @(negedge clk);
    endtask

    initial begin
        int lat;
        int nready;
        #1 rst_n = 1'b0;
        @(negedge clk);
        check("rst_ready", 32'(cpu_ready), 32'd0);
        check("rst_err", 32'(cpu_err), 32'd0);
        check("rst_rdata", cpu_rdata, 32'd0);
        check("rst_fl_re", 32'(fl_re), 32'd0);
        check("rst_fl_addr", 32'(fl_addr), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // cold miss then same-word hit
        read(24'h000104, 1, 40, 32'hDEADBEEF, 0, -1, 32'hDEADBEEF, 0, lat);
        read(24'h000106, 0, 0, 32'h0, 0, -1, 32'hDEADBEEF, 0, lat);

        // conflict on index 1
        read(24'h000044, 1, 5, 32'hA0A00044, 0, -1, 32'hA0A00044, 0, lat);
        read(24'h000444, 1, 7, 32'hB0B00444, 0, -1, 32'hB0B00444, 0, lat);
        read(24'h000044, 1, 3, 32'hA0A00044, 0, -1, 32'hA0A00044, 0, lat);

        // invalidate during WAIT: data returned, line left invalid
        read(24'h000200, 1, 12, 32'h12345678, 0, 6, 32'h12345678, 0, lat);
        read(24'h000200, 1, 4, 32'h12345678, 0, -1, 32'h12345678, 0, lat);
        // invalidate together with a hit: old data returned, then miss
        read(24'h000200, 0, 0, 32'h0, 0, 0, 32'h12345678, 0, lat);
        read(24'h000200, 1, 4, 32'h22222222, 0, -1, 32'h22222222, 0, lat);

        // timeout, then a stray late fl_done
        read(24'h000300, 1, 0, 32'h0, 1, -1, 32'h0, 1, lat);
        check("tmo_window", 32'(lat >= TMO + 2 && lat <= TMO + 4), 32'd1);
        fl_done = 1'b1; fl_rdata = 32'hBADBAD00;
        nready = 0;
        repeat (5) begin
            @(negedge clk);
            fl_done = 1'b0;
            if (cpu_ready) nready++;
        end
        check("stray_ready", 32'(nready), 32'd0);
        read(24'h000300, 1, 5, 32'h00300300, 0, -1, 32'h00300300, 0, lat);

        // reset during WAIT
        read(24'h000500, 1, 6, 32'h00000055, 0, -1, 32'h00000055, 0, lat);
        read(24'h000500, 0, 0, 32'h0, 0, -1, 32'h00000055, 0, lat);
        cpu_req = 1'b1; cpu_addr = 24'h000600;
        repeat (6) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("mid_rst_ready", 32'(cpu_ready), 32'd0);
        check("mid_rst_err", 32'(cpu_err), 32'd0);
        check("mid_rst_rdata", cpu_rdata, 32'd0);
        check("mid_rst_fl_re", 32'(fl_re), 32'd0);
        check("mid_rst_fl_addr", 32'(fl_addr), 32'd0);
        cpu_req = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        read(24'h000500, 1, 6, 32'h00000055, 0, -1, 32'h00000055, 0, lat);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
